trigger_addr_gen: RTL and testbench
===================================

TRIGGER_ADDR_GEN -- requirements
Module: trigger_addr_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, sample-buffer address width.
REQ-002 SHALL have parameter PRE_TRIG_WORDS, default 508, words kept before trigger; legal range 0..2^ADDR_W-1.
REQ-003 SHALL have parameter POST_TRIG_WORDS, default 1016, words written after trigger; legal range 1..2^ADDR_W-PRE_TRIG_WORDS-1.
REQ-004 SHALL have port rx_std_clkout  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port data_valid  in  1  payload word present this cycle.
REQ-007 SHALL have port set_global_trigger  in  1  thresholder decision.
REQ-008 SHALL have port time_stamp  in  16  packet time stamp from thresholder.
REQ-009 SHALL have port readout_done  in  1  single-cycle pulse: captured event read out.
REQ-010 SHALL have port buf_wr_en  out  1  sample-buffer write strobe.
REQ-011 SHALL have port buf_wr_addr  out  ADDR_W  sample-buffer write address.
REQ-012 SHALL have port trig_valid  out  1  captured event ready for readout.
REQ-013 SHALL have port trig_start_addr  out  ADDR_W  first address of event window.
REQ-014 SHALL have port trig_time_stamp  out  16  time stamp latched at trigger.
REQ-015 SHALL have port missed_trig_cnt  out  8  triggers ignored while not ARMED.

Function
REQ-016 SHALL implement FSM states ARMED, POST_TRIG, HOLD.
REQ-017 buf_wr_en SHALL equal data_valid AND state!=HOLD (combinational).
REQ-018 buf_wr_addr SHALL be a register incremented by 1 on every cycle buf_wr_en=1, wrapping 2^ADDR_W-1 -> 0.
REQ-019 ARMED: on set_global_trigger=1, next cycle state=POST_TRIG, trig_time_stamp=time_stamp, trig_start_addr=(buf_wr_addr-PRE_TRIG_WORDS) mod 2^ADDR_W, post counter=0.
REQ-020 POST_TRIG: post counter SHALL increment per buf_wr_en; when the write making count equal POST_TRIG_WORDS occurs, next cycle state=HOLD, trig_valid=1.
REQ-021 HOLD: no writes; trig_valid, trig_start_addr, trig_time_stamp, buf_wr_addr held stable.
REQ-022 HOLD: readout_done=1 SHALL return to ARMED next cycle with trig_valid=0; readout_done outside HOLD SHALL be ignored.
REQ-023 set_global_trigger in POST_TRIG or HOLD SHALL be ignored for capture and increment missed_trig_cnt, saturating at 255.
REQ-024 Trigger and readout_done in the same HOLD cycle: return to ARMED, trigger counted as missed, not captured.
REQ-025 Trigger with data_valid in same ARMED cycle: that word SHALL be written and precedes the window's post-trigger words (not counted).
REQ-026 missed_trig_cnt SHALL clear only on reset.

Reset
REQ-027 rst_n low SHALL immediately force state=ARMED, buf_wr_addr=0, post counter=0, trig_valid=0, trig_start_addr=0, trig_time_stamp=0, missed_trig_cnt=0, including mid-POST_TRIG or HOLD.
REQ-028 Release SHALL be used synchronously; first write after release SHALL go to address 0.

Configuration
REQ-029 Macro TRIG_MISS_CNT_EN defined: missed-trigger counter per REQ-023/026 SHALL be built.
REQ-030 Macro TRIG_MISS_CNT_EN undefined: counter SHALL be absent and missed_trig_cnt tied to 0; all other behaviour unchanged.

Structure
REQ-031 Shared package trig_pkg SHALL hold the FSM state encoding and default values of ADDR_W, PRE_TRIG_WORDS, POST_TRIG_WORDS.
REQ-032 Block SHALL be a single module; no sub-module.

Verification
REQ-033 Reset, 100 data_valid cycles, trigger with buf_wr_addr=600, ts=16'h1234 -> trig_start_addr=92, trig_time_stamp=16'h1234, trig_valid 1 cycle after 1016th post write, buf_wr_addr=1617 frozen.
REQ-034 Trigger at buf_wr_addr=100 -> trig_start_addr=3688 (wrap); post writes wrap past 4095 to 0 correctly.
REQ-035 Three triggers during POST_TRIG, 300 during HOLD -> missed_trig_cnt=255 saturated; without TRIG_MISS_CNT_EN stays 0.
REQ-036 Trigger and readout_done same HOLD cycle -> ARMED next cycle, trig_valid=0, missed count +1, no new capture.
REQ-037 rst_n low mid-POST_TRIG (post count 500) -> all outputs reset values immediately; next trigger captures normally.
REQ-038 data_valid gaps in POST_TRIG -> only valid words counted; trig_valid timing tracks the 1016th write.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared definitions for the trigger address generator: FSM encoding and
// default buffer geometry.
package trig_pkg;

    localparam int unsigned ADDR_W_DEFAULT          = 12;
    localparam int unsigned PRE_TRIG_WORDS_DEFAULT  = 508;
    localparam int unsigned POST_TRIG_WORDS_DEFAULT = 1016;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        POST_TRIG = 2'd1,
        HOLD      = 2'd2
    } trig_state_t;

endpackage

// File: rtl/trigger_addr_gen.sv
// Sample-buffer write address generator with pre/post trigger windowing.
// Optional missed-trigger counter built when TRIG_MISS_CNT_EN is defined.
module trigger_addr_gen
    import trig_pkg::*;
#(
    parameter int unsigned ADDR_W          = ADDR_W_DEFAULT,
    parameter int unsigned PRE_TRIG_WORDS  = PRE_TRIG_WORDS_DEFAULT,
    parameter int unsigned POST_TRIG_WORDS = POST_TRIG_WORDS_DEFAULT
) (
    input  logic              rx_std_clkout,
    input  logic              rst_n,
    input  logic              data_valid,
    input  logic              set_global_trigger,
    input  logic [15:0]       time_stamp,
    input  logic              readout_done,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_addr,
    output logic              trig_valid,
    output logic [ADDR_W-1:0] trig_start_addr,
    output logic [15:0]       trig_time_stamp,
    output logic [7:0]        missed_trig_cnt
);

    localparam logic [ADDR_W-1:0] PRE_OFFSET = ADDR_W'(PRE_TRIG_WORDS);
    localparam logic [ADDR_W-1:0] POST_LAST  = ADDR_W'(POST_TRIG_WORDS - 1);

    trig_state_t       state;
    logic [ADDR_W-1:0] post_cnt;
    logic              trig_missed;

    assign buf_wr_en   = data_valid && (state != HOLD);
    assign trig_missed = set_global_trigger && (state != ARMED);

    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            buf_wr_addr <= '0;
        end else if (buf_wr_en) begin
            buf_wr_addr <= buf_wr_addr + 1'b1;
        end
    end

    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARMED;
            post_cnt        <= '0;
            trig_valid      <= 1'b0;
            trig_start_addr <= '0;
            trig_time_stamp <= '0;
        end else begin
            case (state)
                ARMED: begin
                    // A word written in the trigger cycle belongs to the pre-trigger side.
                    if (set_global_trigger) begin
                        state           <= POST_TRIG;
                        post_cnt        <= '0;
                        trig_start_addr <= buf_wr_addr - PRE_OFFSET;
                        trig_time_stamp <= time_stamp;
                    end
                end
                POST_TRIG: begin
                    if (buf_wr_en) begin
                        post_cnt <= post_cnt + 1'b1;
                        if (post_cnt == POST_LAST) begin
                            state      <= HOLD;
                            trig_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (readout_done) begin
                        state      <= ARMED;
                        trig_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= ARMED;
                    trig_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRIG_MISS_CNT_EN
    always_ff @(posedge rx_std_clkout or negedge rst_n) begin
        if (!rst_n) begin
            missed_trig_cnt <= '0;
        end else if (trig_missed && (missed_trig_cnt != '1)) begin
            missed_trig_cnt <= missed_trig_cnt + 1'b1;
        end
    end
`else
    assign missed_trig_cnt = '0;
    logic unused_missed;
    assign unused_missed = trig_missed;
`endif

endmodule

// File: tb/tb_trigger_addr_gen.sv
// Scoreboard bench for trigger_addr_gen: stimulus queues expected captures,
// a monitor checks each capture when trig_valid rises.
module tb_trigger_addr_gen;
    import trig_pkg::*;

    localparam int unsigned AW   = 12;
    localparam int unsigned PRE  = 508;
    localparam int unsigned POST = 1016;
    localparam int unsigned MASK = (1 << AW) - 1;
`ifdef TRIG_MISS_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        int unsigned start;
        int unsigned ts;
        int unsigned end_addr;
    } cap_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          dv = 1'b0;
    logic          trig = 1'b0;
    logic [15:0]   ts_in = '0;
    logic          rd = 1'b0;
    logic          buf_wr_en;
    logic [AW-1:0] buf_wr_addr;
    logic          trig_valid;
    logic [AW-1:0] trig_start_addr;
    logic [15:0]   trig_time_stamp;
    logic [7:0]    missed_trig_cnt;

    cap_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;
    int unsigned addr_m = 0;
    int unsigned cnt_m = 0;
    logic        tv_prev = 1'b0;

    trigger_addr_gen #(
        .ADDR_W(AW),
        .PRE_TRIG_WORDS(PRE),
        .POST_TRIG_WORDS(POST)
    ) dut (
        .rx_std_clkout(clk),
        .rst_n(rst_n),
        .data_valid(dv),
        .set_global_trigger(trig),
        .time_stamp(ts_in),
        .readout_done(rd),
        .buf_wr_en(buf_wr_en),
        .buf_wr_addr(buf_wr_addr),
        .trig_valid(trig_valid),
        .trig_start_addr(trig_start_addr),
        .trig_time_stamp(trig_time_stamp),
        .missed_trig_cnt(missed_trig_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && trig_valid && !tv_prev) begin
            if (exp_q.size() == 0) begin
                check("unexpected_capture", 1, 0);
            end else begin
                cap_t e;
                e = exp_q.pop_front();
                check("cap_start_addr", trig_start_addr, e.start);
                check("cap_time_stamp", trig_time_stamp, e.ts);
                check("cap_end_addr", buf_wr_addr, e.end_addr);
            end
        end
        tv_prev <= trig_valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic miss();
        if (CNT_EN && cnt_m < 255) cnt_m++;
    endtask

    task automatic wr(input int unsigned n);
        dv = 1'b1;
        repeat (n) begin
            tick();
            addr_m = (addr_m + 1) & MASK;
        end
        dv = 1'b0;
    endtask

    task automatic fire(input logic [15:0] ts, input bit expect_capture);
        cap_t e;
        e.start    = (addr_m - PRE) & MASK;
        e.ts       = ts;
        e.end_addr = (addr_m + 1 + POST) & MASK;
        if (expect_capture) exp_q.push_back(e);
        trig  = 1'b1;
        ts_in = ts;
        dv    = 1'b1;
        tick();
        addr_m = (addr_m + 1) & MASK;
        trig  = 1'b0;
        dv    = 1'b0;
        ts_in = '0;
        check("trig_valid_after_fire", trig_valid, 0);
    endtask

    // n valid post words; every `gap` words an idle cycle, which carries a
    // trigger while `misses` remain.
    task automatic post(input int unsigned n, input int unsigned gap, input int unsigned misses);
        int unsigned left = misses;
        for (int unsigned i = 1; i <= n; i++) begin
            wr(1);
            if (gap != 0 && (i % gap) == 0) begin
                trig = (left != 0);
                tick();
                if (left != 0) begin
                    miss();
                    left--;
                end
                trig = 1'b0;
            end
        end
    endtask

    task automatic readout();
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("trig_valid_after_readout", trig_valid, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #23;
        check("rst_addr", buf_wr_addr, 0);
        check("rst_trig_valid", trig_valid, 0);
        check("rst_start", trig_start_addr, 0);
        check("rst_ts", trig_time_stamp, 0);
        check("rst_missed", missed_trig_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Window at 600 with valid-data gaps and three missed triggers.
        wr(600);
        check("addr_600", buf_wr_addr, 600);
        fire(16'h1234, 1'b1);
        check("start_92", trig_start_addr, 92);
        post(POST - 1, 7, 3);
        check("tv_before_last_post", trig_valid, 0);
        check("missed_in_post", missed_trig_cnt, cnt_m);
        wr(1);
        check("tv_after_last_post", trig_valid, 1);
        dv = 1'b1;
        #1;
        check("hold_wr_en", buf_wr_en, 0);
        repeat (5) tick();
        dv = 1'b0;
        check("hold_addr_1617", buf_wr_addr, 1617);
        check("hold_tv", trig_valid, 1);
        check("hold_ts", trig_time_stamp, 16'h1234);

        // Trigger together with readout_done: counted, not captured.
        trig = 1'b1;
        rd   = 1'b1;
        tick();
        miss();
        trig = 1'b0;
        rd   = 1'b0;
        check("same_cycle_tv", trig_valid, 0);
        check("same_cycle_missed", missed_trig_cnt, cnt_m);
        dv = 1'b1;
        #1;
        check("armed_wr_en", buf_wr_en, 1);
        dv = 1'b0;
        rd = 1'b1;
        tick();
        rd = 1'b0;

        // Wrapped start address.
        wr(4096 - 1617 + 100);
        check("addr_100", buf_wr_addr, 100);
        fire(16'hBEEF, 1'b1);
        check("start_3688", trig_start_addr, 3688);
        post(POST, 0, 0);
        check("tv_wrap_start", trig_valid, 1);
        readout();

        // Post window wrapping past the top of the buffer, then saturation.
        wr(3500 - 1117);
        check("addr_3500", buf_wr_addr, 3500);
        fire(16'h5A5A, 1'b1);
        post(POST, 0, 0);
        check("addr_421", buf_wr_addr, 421);
        trig = 1'b1;
        repeat (300) begin
            tick();
            miss();
        end
        trig = 1'b0;
        check("missed_sat", missed_trig_cnt, cnt_m);
        check("missed_sat_val", missed_trig_cnt, CNT_EN ? 255 : 0);
        readout();

        // Asynchronous reset part way through a post window.
        fire(16'h7777, 1'b0);
        post(500, 0, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", buf_wr_addr, 0);
        check("mid_rst_start", trig_start_addr, 0);
        check("mid_rst_ts", trig_time_stamp, 0);
        check("mid_rst_tv", trig_valid, 0);
        check("mid_rst_missed", missed_trig_cnt, 0);
        addr_m = 0;
        cnt_m  = 0;
        #2;
        rst_n = 1'b1;
        tick();
        check("post_rst_addr0", buf_wr_addr, 0);
        wr(1);
        check("post_rst_addr1", buf_wr_addr, 1);
        wr(9);
        fire(16'h0F0F, 1'b1);
        check("start_3598", trig_start_addr, 3598);
        post(POST, 0, 0);
        check("tv_after_rst", trig_valid, 1);
        check("addr_1027", buf_wr_addr, 1027);
        readout();

        repeat (2) tick();
        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
